// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parameterised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, overflow/underflow
// pulses and a selectable read mode (standard registered read or FWFT).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   wr_en, wdata  write request and data
//   rd_en         read (pop) request
//   rdata         read data (registered in standard mode, mem[rptr] in FWFT)
//   full, empty, almost_full, almost_empty   registered status flags
//   count         registered occupancy, 0..DEPTH
//   overflow      one-cycle pulse after a write attempted while full
//   underflow     one-cycle pulse after a read attempted while empty
module fifo_sync_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;

  logic              wr_acc_c;
  logic              rd_acc_c;
  logic [CNT_W-1:0]  count_next_c;

  // Acceptance uses the registered flags, so a full FIFO still pops on a
  // simultaneous request and an empty FIFO still pushes.
  assign wr_acc_c = wr_en && !full;
  assign rd_acc_c = rd_en && !empty;

  // Next occupancy; a simultaneous accepted push and pop cancel out.
  always_comb begin
    count_next_c = count;
    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_next_c = count + CNT_W'(1);
      2'b01:   count_next_c = count - CNT_W'(1);
      default: count_next_c = count;
    endcase
  end

  // Pointers, count, and flags registered from the next count so every
  // flag changes on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc_c) wptr <= wptr + ADDR_W'(1);
      if (rd_acc_c) rptr <= rptr + ADDR_W'(1);
      count        <= count_next_c;
      full         <= (count_next_c == CNT_W'(DEPTH));
      empty        <= (count_next_c == '0);
      almost_full  <= (count_next_c >= CNT_W'(AFULL_TH));
      almost_empty <= (count_next_c <= CNT_W'(AEMPTY_TH));
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[wptr] <= wdata;
  end

  // Read-data path per read mode.
  if (FWFT == 0) begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rdata <= '0;
      else if (rd_acc_c) rdata <= mem[rptr];
    end
  end else begin : g_fwft
    assign rdata = mem[rptr];
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param. Three instances share one stimulus
// stream: defaults/standard read, defaults/FWFT, and a small 8-deep 16-bit
// instance that wraps its pointers often. Each instance has a queue model.
module tb_fifo_sync_param;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] wdata = '0;

  always #5 clk = ~clk;

  logic [7:0]  rd0, rd1;
  logic [15:0] rd2;
  logic [4:0]  c0, c1;
  logic [3:0]  c2;
  logic        full_o [3];
  logic        empty_o[3];
  logic        af_o   [3];
  logic        ae_o   [3];
  logic        ovf_o  [3];
  logic        udf_o  [3];
  logic [15:0] rd_o   [3];
  logic [4:0]  cnt_o  [3];

  assign rd_o[0]  = {8'h00, rd0};
  assign rd_o[1]  = {8'h00, rd1};
  assign rd_o[2]  = rd2;
  assign cnt_o[0] = c0;
  assign cnt_o[1] = c1;
  assign cnt_o[2] = {1'b0, c2};

  fifo_sync_param u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata[7:0]), .rd_en(rd_en),
    .rdata(rd0), .full(full_o[0]), .empty(empty_o[0]), .almost_full(af_o[0]),
    .almost_empty(ae_o[0]), .count(c0), .overflow(ovf_o[0]), .underflow(udf_o[0])
  );

  fifo_sync_param #(.FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata[7:0]), .rd_en(rd_en),
    .rdata(rd1), .full(full_o[1]), .empty(empty_o[1]), .almost_full(af_o[1]),
    .almost_empty(ae_o[1]), .count(c1), .overflow(ovf_o[1]), .underflow(udf_o[1])
  );

  fifo_sync_param #(.DATA_W(16), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rd2), .full(full_o[2]), .empty(empty_o[2]), .almost_full(af_o[2]),
    .almost_empty(ae_o[2]), .count(c2), .overflow(ovf_o[2]), .underflow(udf_o[2])
  );

  // Reference model: per-instance contents queue plus expected registered outputs.
  int          dep [3] = '{16, 16, 8};
  int          aft [3] = '{12, 12, 6};
  int          aet [3] = '{2, 2, 1};
  int          fw  [3] = '{0, 1, 0};
  logic [15:0] msk [3] = '{16'h00ff, 16'h00ff, 16'hffff};
  logic [15:0] q0[$], q1[$], q2[$];
  logic [15:0] exp_rd [3];
  logic        exp_ovf[3];
  logic        exp_udf[3];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [15:0] qfront(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int k, output logic [15:0] d);
    case (k)
      0:       d = q0.pop_front();
      1:       d = q1.pop_front();
      default: d = q2.pop_front();
    endcase
  endtask

  task automatic qpush(input int k, input logic [15:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) begin
      exp_rd[k]  = '0;
      exp_ovf[k] = 1'b0;
      exp_udf[k] = 1'b0;
    end
  endtask

  // Apply one clock edge worth of FIFO rules to every model.
  task automatic model_step(input logic w, input logic r, input logic [15:0] d);
    int          sz;
    logic [15:0] front;
    for (int k = 0; k < 3; k++) begin
      sz         = qsize(k);
      exp_ovf[k] = w && (sz == dep[k]);
      exp_udf[k] = r && (sz == 0);
      if (r && sz != 0) begin
        qpop(k, front);
        if (fw[k] == 0) exp_rd[k] = front;
      end
      if (w && sz != dep[k]) qpush(k, d & msk[k]);
    end
  endtask

  task automatic check_all();
    int sz;
    for (int k = 0; k < 3; k++) begin
      sz = qsize(k);
      check($sformatf("d%0d.count", k), 32'(cnt_o[k]), 32'(sz));
      check($sformatf("d%0d.full", k), 32'(full_o[k]), 32'(sz == dep[k]));
      check($sformatf("d%0d.empty", k), 32'(empty_o[k]), 32'(sz == 0));
      check($sformatf("d%0d.almost_full", k), 32'(af_o[k]), 32'(sz >= aft[k]));
      check($sformatf("d%0d.almost_empty", k), 32'(ae_o[k]), 32'(sz <= aet[k]));
      check($sformatf("d%0d.overflow", k), 32'(ovf_o[k]), 32'(exp_ovf[k]));
      check($sformatf("d%0d.underflow", k), 32'(udf_o[k]), 32'(exp_udf[k]));
      if (fw[k] == 0)
        check($sformatf("d%0d.rdata", k), 32'(rd_o[k]), 32'(exp_rd[k]));
      else if (sz != 0)
        check($sformatf("d%0d.rdata_fwft", k), 32'(rd_o[k]), 32'(qfront(k)));
    end
  endtask

  // Called just after a falling edge: drive, clock once, check at next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [15:0] d);
    wr_en = w;
    rd_en = r;
    wdata = d;
    if (rst_n) model_step(w, r, d);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Assert reset between edges and confirm the outputs clear immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int pw, pr;
    model_reset();
    // Reset held 200 ns with random requests.
    for (int i = 0; i < 20; i++)
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom));
    rst_n = 1'b1;

    // Fill 0..15 then an extra write of 0xAA.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 16'(i));
    cycle(1'b1, 1'b0, 16'h00AA);
    // Simultaneous request while full.
    cycle(1'b1, 1'b1, 16'h0033);
    // Drain past empty.
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 16'h0);
    // Simultaneous request while empty, then pop it.
    cycle(1'b1, 1'b1, 16'h0044);
    cycle(1'b0, 1'b1, 16'h0);
    // FWFT fall-through of a single word.
    cycle(1'b1, 1'b0, 16'h005A);
    check("fwft.rdata_5a", 32'(rd_o[1]), 32'h5A);
    check("fwft.empty_low", 32'(empty_o[1]), 32'h0);
    cycle(1'b0, 1'b1, 16'h0);
    check("fwft.empty_after_pop", 32'(empty_o[1]), 32'h1);

    // Hold count at 7 with simultaneous requests.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b1, 16'($urandom));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'h0);

    // Wrap sequence: 5 writes, 5 reads, 20 interleaved.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 16'($urandom));

    // Reset mid-operation with data inside.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'($urandom));
    async_reset();

    // Random traffic with shifting write/read bias.
    for (int i = 0; i < 1500; i++) begin
      case ((i / 100) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      if (i == 700) async_reset();
      cycle(1'($urandom_range(99) < 32'(pw)), 1'($urandom_range(99) < 32'(pr)),
            16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
